// File: rtl/mult_pkg.sv
// Shared defaults and tag-width helper for the shared-multiplier scheduler slice.
package mult_pkg;

    localparam int N_DEF   = 16;
    localparam int Q_DEF   = 10;
    localparam int NREQ_DEF = 4;

    // Tag width for n requesters; never below one bit so a 1-bit id always exists.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester operand bus and result bus of the shared-multiplier scheduler.
interface mult_share_sched_if
    import mult_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NUM_REQ = NREQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]   i_req_valid;
    logic [NUM_REQ*N-1:0] i_req_a;
    logic [NUM_REQ*N-1:0] i_req_b;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic                 o_res_valid;
    logic [N-1:0]         o_res_data;
    logic [ID_W-1:0]      o_res_id;
    logic                 i_res_ready;

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_res_ready,
        input  o_req_ready, o_res_valid, o_res_data, o_res_id
    );

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_res_ready,
        output o_req_ready, o_res_valid, o_res_data, o_res_id
    );

endinterface

// File: rtl/m_mult.sv
// Signed N-bit fixed-point multiplier with Q fractional bits; result truncated to N bits.
module m_mult
    import mult_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
)(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_p
);

    logic signed [2*N-1:0] w_full;
    logic                  w_unused;

    assign w_full = $signed(i_a) * $signed(i_b);
    // Drop Q low fraction bits and wrap on overflow; no rounding or saturation.
    assign o_p      = w_full[Q +: N];
    assign w_unused = ^{w_full[2*N-1:N+Q], w_full[Q-1:0]};

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: first requester at or above i_ptr (with wrap) wins; grant gated by i_en.
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_any
);

    int unsigned w_k;

    always_comb begin
        o_any     = 1'b0;
        o_gnt_idx = '0;
        o_gnt     = '0;
        w_k       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = 32'(i_ptr) + i;
            if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
            if (!o_any && i_req[w_k[ID_W-1:0]]) begin
                o_any     = 1'b1;
                o_gnt_idx = w_k[ID_W-1:0];
            end
        end
        if (i_en && o_any) o_gnt[o_gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/mult_share_sched.sv
// Time-multiplexes one m_mult among NUM_REQ requesters through a tagged, stall-as-a-whole pipeline.
module mult_share_sched
    import mult_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int Q       = Q_DEF,
    parameter int NUM_REQ = NREQ_DEF,
    parameter int LAT     = 2
)(
    input logic              clk,
    input logic              rst,
    mult_share_sched_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    logic               w_adv;
    logic               w_en;
    logic               w_any;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    r_ptr;
    logic [N-1:0]       w_sel_a;
    logic [N-1:0]       w_sel_b;
    logic [N-1:0]       r_s0_a;
    logic [N-1:0]       r_s0_b;
    logic [ID_W-1:0]    r_s0_id;
    logic               r_s0_v;
    logic [N-1:0]       w_prod;
    logic               w_out_v;
    logic [N-1:0]       w_out_data;
    logic [ID_W-1:0]    w_out_id;

    // Entire pipeline moves in lockstep; bubbles at the output never block.
    assign w_adv  = !w_out_v || bus.i_res_ready;
    assign w_en   = w_adv && !rst;
    assign w_xfer = w_any && w_en;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req     (bus.i_req_valid),
        .i_ptr     (r_ptr),
        .i_en      (w_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_idx == ID_W'(k)) begin
                w_sel_a = bus.i_req_a[k*N +: N];
                w_sel_b = bus.i_req_b[k*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_s0_v  <= 1'b0;
            r_s0_a  <= '0;
            r_s0_b  <= '0;
            r_s0_id <= '0;
        end else if (w_adv) begin
            r_s0_v  <= w_xfer;
            r_s0_a  <= w_sel_a;
            r_s0_b  <= w_sel_b;
            r_s0_id <= w_gnt_idx;
            if (w_xfer) begin
                r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    m_mult #(
        .N (N),
        .Q (Q)
    ) u_mult (
        .i_a (r_s0_a),
        .i_b (r_s0_b),
        .o_p (w_prod)
    );

    if (LAT == 1) begin : g_lat1
        assign w_out_v    = r_s0_v;
        assign w_out_data = w_prod;
        assign w_out_id   = r_s0_id;
    end else begin : g_pipe
        logic [N-1:0]    r_pd  [LAT-1];
        logic [ID_W-1:0] r_pid [LAT-1];
        logic            r_pv  [LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned s = 0; s < LAT - 1; s++) begin
                    r_pd[s]  <= '0;
                    r_pid[s] <= '0;
                    r_pv[s]  <= 1'b0;
                end
            end else if (w_adv) begin
                r_pd[0]  <= w_prod;
                r_pid[0] <= r_s0_id;
                r_pv[0]  <= r_s0_v;
                for (int unsigned s = 1; s < LAT - 1; s++) begin
                    r_pd[s]  <= r_pd[s-1];
                    r_pid[s] <= r_pid[s-1];
                    r_pv[s]  <= r_pv[s-1];
                end
            end
        end

        assign w_out_v    = r_pv[LAT-2];
        assign w_out_data = r_pd[LAT-2];
        assign w_out_id   = r_pid[LAT-2];
    end

    assign bus.o_req_ready = w_gnt;
    assign bus.o_res_valid = w_out_v;
    assign bus.o_res_data  = w_out_data;
    assign bus.o_res_id    = w_out_id;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (N=16, Q=10, NUM_REQ=4, LAT=2).
module tb_mult_share_sched;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mult_share_sched_if #(.N(16), .NUM_REQ(4)) bus ();

    mult_share_sched #(
        .N       (16),
        .Q       (10),
        .NUM_REQ (4),
        .LAT     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
        bus.i_req_a[k*16 +: 16] = a;
        bus.i_req_b[k*16 +: 16] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_res_ready = 1'b1;
        bus.i_req_valid = 4'hF;
        for (int k = 0; k < 4; k++) set_op(k, 16'h0400, 16'h0400);
        step();
        step();
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b exp=0000", bus.o_req_ready);
        end
        checks++;
        if (bus.o_res_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_res_valid);
        end
        checks++;
        if (bus.o_res_data !== 16'h0000) begin
            failures++; $display("FAIL reset_data got=%h exp=0000", bus.o_res_data);
        end
        checks++;
        if (bus.o_res_id !== 2'd0) begin
            failures++; $display("FAIL reset_id got=%0d exp=0", bus.o_res_id);
        end
        rst = 1'b0;
        bus.i_req_valid = '0;
        step();
    endtask

    task automatic test_single();
        set_op(1, 16'h0600, 16'h0800);
        bus.i_req_valid = 4'b0010;
        bus.i_res_ready = 1'b1;
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b0010) begin
            failures++; $display("FAIL single_ready got=%b exp=0010", bus.o_req_ready);
        end
        step();
        bus.i_req_valid = '0;
        #1;
        checks++;
        if (bus.o_res_valid !== 1'b0) begin
            failures++; $display("FAIL single_early got=%b exp=0", bus.o_res_valid);
        end
        step();
        #1;
        checks++;
        if (bus.o_res_valid !== 1'b1 || bus.o_res_data !== 16'h0C00 || bus.o_res_id !== 2'd1) begin
            failures++;
            $display("FAIL single_result got v=%b data=%h id=%0d exp v=1 data=0c00 id=1",
                     bus.o_res_valid, bus.o_res_data, bus.o_res_id);
        end
        step();
        #1;
        checks++;
        if (bus.o_res_valid !== 1'b0) begin
            failures++; $display("FAIL single_once got=%b exp=0", bus.o_res_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) set_op(k, 16'((k + 1) * 1024), 16'h0400);
        for (int c = 0; c < 10; c++) begin
            bus.i_req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                checks++;
                if (bus.o_req_ready !== 4'(1 << (c % 4))) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.o_req_ready, 4'(1 << (c % 4)));
                end
            end
            checks++;
            if (c < 2) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL rr_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'((c - 2) % 4)
                         || bus.o_res_data !== 16'(((c - 2) % 4 + 1) * 1024)) begin
                failures++;
                $display("FAIL rr_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, (c - 2) % 4,
                         16'(((c - 2) % 4 + 1) * 1024));
            end
            step();
        end
        #1;
        checks++;
        if (bus.o_res_valid !== 1'b0) begin
            failures++; $display("FAIL rr_drain got=%b exp=0", bus.o_res_valid);
        end
    endtask

    task automatic test_backpressure();
        logic        rr [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        logic [3:0]  v  [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        logic [3:0]  r  [10] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        int          id [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
        logic [15:0] d  [10] = '{16'h0, 16'h0, 16'h0800, 16'h0800, 16'h0800, 16'h0800,
                                 16'h1000, 16'h1800, 16'h2000, 16'h0};
        for (int k = 0; k < 4; k++) set_op(k, 16'((k + 1) * 1024), 16'h0800);
        for (int c = 0; c < 10; c++) begin
            bus.i_res_ready = rr[c];
            bus.i_req_valid = v[c];
            #1;
            checks++;
            if (bus.o_req_ready !== r[c]) begin
                failures++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.o_req_ready, r[c]);
            end
            checks++;
            if (id[c] < 0) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL bp_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'(id[c]) || bus.o_res_data !== d[c]) begin
                failures++;
                $display("FAIL bp_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, id[c], d[c]);
            end
            step();
        end
        bus.i_res_ready = 1'b1;
    endtask

    task automatic test_ptr_wrap();
        logic [3:0]  v  [6] = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  r  [6] = '{4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        int          id [6] = '{-1, -1, 3, 0, 3, -1};
        logic [15:0] d  [6] = '{16'h0, 16'h0, 16'h0C00, 16'h0200, 16'h0400, 16'h0};
        set_op(3, 16'h0C00, 16'h0400);
        set_op(0, 16'h0200, 16'h0400);
        for (int c = 0; c < 6; c++) begin
            bus.i_req_valid = v[c];
            if (c == 1) set_op(3, 16'h0400, 16'h0400);
            #1;
            checks++;
            if (bus.o_req_ready !== r[c]) begin
                failures++; $display("FAIL wrap_ready c=%0d got=%b exp=%b", c, bus.o_req_ready, r[c]);
            end
            checks++;
            if (id[c] < 0) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL wrap_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'(id[c]) || bus.o_res_data !== d[c]) begin
                failures++;
                $display("FAIL wrap_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, id[c], d[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        logic        rs [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        logic [3:0]  v  [8] = '{4'b0010, 4'b0100, 4'b1100, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  r  [8] = '{4'b0010, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        int          id [8] = '{-1, -1, 1, -1, -1, 2, 3, -1};
        logic [15:0] d  [8] = '{16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h0A00, 16'hFE00, 16'h0};
        set_op(1, 16'h0400, 16'h0400);
        set_op(2, 16'h0A00, 16'h0400);
        set_op(3, 16'h0400, 16'hFE00);
        for (int c = 0; c < 8; c++) begin
            rst = rs[c];
            bus.i_req_valid = v[c];
            #1;
            checks++;
            if (bus.o_req_ready !== r[c]) begin
                failures++; $display("FAIL rstmid_ready c=%0d got=%b exp=%b", c, bus.o_req_ready, r[c]);
            end
            checks++;
            if (id[c] < 0) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL rstmid_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'(id[c]) || bus.o_res_data !== d[c]) begin
                failures++;
                $display("FAIL rstmid_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, id[c], d[c]);
            end
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_negative();
        logic [3:0]  v  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        int          id [6] = '{-1, -1, 0, 1, 2, -1};
        logic [15:0] d  [6] = '{16'h0, 16'h0, 16'hF800, 16'h0400, 16'hF800, 16'h0};
        set_op(0, 16'hFC00, 16'h0800);
        set_op(1, 16'hFC00, 16'hFC00);
        set_op(2, 16'h7C00, 16'h0800);
        for (int c = 0; c < 6; c++) begin
            bus.i_req_valid = v[c];
            #1;
            checks++;
            if (bus.o_req_ready !== v[c]) begin
                failures++; $display("FAIL neg_ready c=%0d got=%b exp=%b", c, bus.o_req_ready, v[c]);
            end
            checks++;
            if (id[c] < 0) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL neg_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'(id[c]) || bus.o_res_data !== d[c]) begin
                failures++;
                $display("FAIL neg_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, id[c], d[c]);
            end
            step();
        end
    endtask

    task automatic test_bubble_stall();
        logic        rr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic [3:0]  v  [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  r  [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        int          id [8] = '{-1, -1, 0, 0, 0, 1, 2, -1};
        logic [15:0] d  [8] = '{16'h0, 16'h0, 16'h0400, 16'h0400, 16'h0400, 16'h0800, 16'h1800, 16'h0};
        set_op(0, 16'h0400, 16'h0400);
        set_op(1, 16'h0800, 16'h0400);
        set_op(2, 16'h0C00, 16'h0800);
        for (int c = 0; c < 8; c++) begin
            bus.i_res_ready = rr[c];
            bus.i_req_valid = v[c];
            #1;
            checks++;
            if (bus.o_req_ready !== r[c]) begin
                failures++; $display("FAIL bubble_ready c=%0d got=%b exp=%b", c, bus.o_req_ready, r[c]);
            end
            checks++;
            if (id[c] < 0) begin
                if (bus.o_res_valid !== 1'b0) begin
                    failures++; $display("FAIL bubble_empty c=%0d got=%b exp=0", c, bus.o_res_valid);
                end
            end else if (bus.o_res_valid !== 1'b1 || bus.o_res_id !== 2'(id[c]) || bus.o_res_data !== d[c]) begin
                failures++;
                $display("FAIL bubble_result c=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c,
                         bus.o_res_valid, bus.o_res_id, bus.o_res_data, id[c], d[c]);
            end
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_res_ready = 1'b1;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ptr_wrap();
        test_reset_midflight();
        test_negative();
        test_bubble_stall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
